// File: rtl/keccak_pkg.sv
`default_nettype none
// ============================================================================
// Package : keccak_pkg
// Shared state encoding and byte-lane ordering for the keccak front end.
// Rev 1.0
// ============================================================================
package keccak_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        CLOSE = 2'd1,
        DONE  = 2'd2
    } packer_state_e;

    localparam int unsigned BYTES_PER_WORD = 4;

    // First byte of a word occupies [31:24]; the core's padder assumes the same.
    localparam bit LANE_MSB_FIRST = 1'b1;

    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [4:0] sh;
        sh = LANE_MSB_FIRST ? {~lane, 3'b000} : {lane, 3'b000};
        return word | ({24'd0, b} << sh);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keccak_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : keccak_byte_packer
// Packs a valid/ready byte stream into 32-bit words for the keccak core and
// emits the closing partial/empty word. Optional: KECCAK_PACKER_SKID_EN.
// Rev 1.0
// ============================================================================
module keccak_byte_packer
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        byte_last,
    input  logic        msg_end,
    output logic        byte_ready,
    output logic [31:0] in,
    output logic        in_ready,
    output logic        is_last,
    output logic [1:0]  byte_num,
    input  logic        buffer_full,
    output logic        done
);

    localparam logic [2:0] FULL_CNT = 3'(BYTES_PER_WORD);

    packer_state_e state_q, state_d;
    logic [31:0]   fill_q, fill_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   pend_word_q, pend_word_d;
    logic          pend_last_q, pend_last_d;
    logic [1:0]    pend_bnum_q, pend_bnum_d;
    logic          pend_valid_q, pend_valid_d;
    logic          final_loaded_q, final_loaded_d;

    logic w_room;
    logic w_accept;
    logic w_xfer;
    logic w_pend_free;
    logic w_end;

`ifdef KECCAK_PACKER_SKID_EN
    assign w_room = ~((cnt_q == FULL_CNT) & pend_valid_q);
`else
    assign w_room = ~pend_valid_q;
`endif

    assign byte_ready  = (state_q == FILL) & ~reset & w_room;
    assign w_accept    = byte_valid & byte_ready;
    assign w_xfer      = pend_valid_q & ~buffer_full & ~reset;
    assign w_pend_free = ~pend_valid_q | w_xfer;
    assign w_end       = (w_accept & byte_last) | msg_end;

    assign in       = w_xfer ? pend_word_q : 32'd0;
    assign in_ready = w_xfer;
    assign is_last  = w_xfer & pend_last_q;
    assign byte_num = is_last ? pend_bnum_q : 2'd0;
    assign done     = (state_q == DONE);

    always_comb begin
        state_d        = state_q;
        fill_d         = fill_q;
        cnt_d          = cnt_q;
        pend_word_d    = pend_word_q;
        pend_last_d    = pend_last_q;
        pend_bnum_d    = pend_bnum_q;
        pend_valid_d   = pend_valid_q & ~w_xfer;
        final_loaded_d = final_loaded_q;

        case (state_q)
            FILL: begin
                if (w_accept) begin
                    fill_d = lane_insert(fill_q, cnt_q[1:0], byte_in);
                    cnt_d  = cnt_q + 3'd1;
                end
                if ((cnt_d == FULL_CNT) && w_pend_free) begin
                    pend_word_d  = fill_d;
                    pend_last_d  = 1'b0;
                    pend_bnum_d  = 2'd0;
                    pend_valid_d = 1'b1;
                    fill_d       = 32'd0;
                    cnt_d        = 3'd0;
                end
                if (w_end) begin
                    state_d = CLOSE;
                end
            end
            CLOSE: begin
                // A full fill leaves as a normal word; the zeroed fill then
                // becomes the empty closing word on a later pass.
                if (!final_loaded_q && w_pend_free) begin
                    pend_word_d    = fill_q;
                    pend_last_d    = (cnt_q != FULL_CNT);
                    pend_bnum_d    = cnt_q[1:0];
                    pend_valid_d   = 1'b1;
                    final_loaded_d = (cnt_q != FULL_CNT);
                    fill_d         = 32'd0;
                    cnt_d          = 3'd0;
                end
                if (w_xfer && pend_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= FILL;
            fill_q         <= 32'd0;
            cnt_q          <= 3'd0;
            pend_word_q    <= 32'd0;
            pend_last_q    <= 1'b0;
            pend_bnum_q    <= 2'd0;
            pend_valid_q   <= 1'b0;
            final_loaded_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_q         <= fill_d;
            cnt_q          <= cnt_d;
            pend_word_q    <= pend_word_d;
            pend_last_q    <= pend_last_d;
            pend_bnum_q    <= pend_bnum_d;
            pend_valid_q   <= pend_valid_d;
            final_loaded_q <= final_loaded_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keccak_byte_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_keccak_byte_packer
// Directed self-checking bench for keccak_byte_packer.
// Rev 1.0
// ============================================================================
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_last;
    logic        msg_end;
    logic        byte_ready;
    logic [31:0] in_w;
    logic        in_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        buffer_full;
    logic        done;

    keccak_byte_packer dut (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .msg_end    (msg_end),
        .byte_ready (byte_ready),
        .in         (in_w),
        .in_ready   (in_ready),
        .is_last    (is_last),
        .byte_num   (byte_num),
        .buffer_full(buffer_full),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_acc_cyc;
    int done_cyc;
    int bf_viol;
    int stall;
    bit stream_timeout;

    logic [31:0] s_in;
    logic        s_in_ready, s_is_last, s_byte_ready, s_done;
    logic [1:0]  s_bnum;

    logic [31:0] log_word[$];
    logic        log_last[$];
    logic [1:0]  log_bnum[$];
    int          log_cyc[$];

    logic [7:0]  msg[16];

`ifdef KECCAK_PACKER_SKID_EN
    localparam int EXP_STALL = 6;
`else
    localparam int EXP_STALL = 10;
`endif

    // Inputs are set after a falling edge; outputs sampled 1ns later.
    task automatic tick;
        #1;
        s_in         = in_w;
        s_in_ready   = in_ready;
        s_is_last    = is_last;
        s_bnum       = byte_num;
        s_byte_ready = byte_ready;
        s_done       = done;
        if (s_in_ready === 1'b1) begin
            log_word.push_back(s_in);
            log_last.push_back(s_is_last);
            log_bnum.push_back(s_bnum);
            log_cyc.push_back(cyc);
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_log;
        log_word.delete();
        log_last.delete();
        log_bnum.delete();
        log_cyc.delete();
    endtask

    task automatic idle_inputs;
        byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0;
        msg_end = 1'b0;  buffer_full = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_log();
    endtask

    // Streams msg[0..n-1], byte_last on the final byte. If bf_hold>0,
    // buffer_full is held high for bf_hold cycles after the 4th byte.
    task automatic stream(input int n, input int bf_hold);
        int idx = 0;
        int bfc = 0;
        int budget = 0;
        bf_viol = 0;
        stall = 0;
        while (idx < n && budget < 200) begin
            byte_in     = msg[idx];
            byte_valid  = 1'b1;
            byte_last   = (idx == n - 1);
            buffer_full = (bfc > 0);
            tick();
            if (bfc > 0) begin
                bfc--;
                if (s_in_ready) bf_viol++;
                if (!s_byte_ready) stall++;
            end
            if (s_byte_ready) begin
                idx++;
                last_acc_cyc = cyc - 1;
                if (idx == 4 && bf_hold > 0) bfc = bf_hold;
            end
            budget++;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        while (bfc > 0) begin
            buffer_full = 1'b1;
            tick();
            bfc--;
            if (s_in_ready) bf_viol++;
        end
        buffer_full = 1'b0;
        stream_timeout = (idx < n);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_done) begin
                ok = 1'b1;
                done_cyc = cyc - 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b1; byte_valid = 1'b1; byte_in = 8'h55;
        tick();
        n_checks++;
        if (s_byte_ready !== 1'b0) $display("FAIL reset_byte_ready: got %b want 0", s_byte_ready); else n_pass++;
        n_checks++;
        if (s_in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", s_in_ready); else n_pass++;
        tick();
        reset = 1'b0; byte_valid = 1'b0;
        clear_log();
        tick();
        n_checks++;
        if (s_in !== 32'd0) $display("FAIL rst_in: got %h want 0", s_in); else n_pass++;
        n_checks++;
        if (s_in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", s_in_ready); else n_pass++;
        n_checks++;
        if (s_is_last !== 1'b0) $display("FAIL rst_is_last: got %b want 0", s_is_last); else n_pass++;
        n_checks++;
        if (s_bnum !== 2'd0) $display("FAIL rst_byte_num: got %0d want 0", s_bnum); else n_pass++;
        n_checks++;
        if (s_done !== 1'b0) $display("FAIL rst_done: got %b want 0", s_done); else n_pass++;
        n_checks++;
        if (s_byte_ready !== 1'b1) $display("FAIL rst_byte_ready_after: got %b want 1", s_byte_ready); else n_pass++;
    endtask

    task automatic test_empty_msg;
        bit ok;
        do_reset();
        msg_end = 1'b1;
        tick();
        msg_end = 1'b0;
        wait_done(ok);
        tick(); tick();
        n_checks++;
        if (!ok) $display("FAIL empty_done_timeout: got done=0 want 1"); else n_pass++;
        n_checks++;
        if (log_word.size() != 1) $display("FAIL empty_xfer_count: got %0d want 1", log_word.size());
        else if (log_word[0] !== 32'd0 || log_last[0] !== 1'b1 || log_bnum[0] !== 2'd0)
            $display("FAIL empty_word: got %h last=%b bn=%0d want 0 last=1 bn=0", log_word[0], log_last[0], log_bnum[0]);
        else n_pass++;
        n_checks++;
        if (log_cyc.size() == 0 || done_cyc != log_cyc[0] + 1)
            $display("FAIL empty_done_timing: got done at %0d want one after transfer", done_cyc);
        else n_pass++;
    endtask

    task automatic test_abc;
        bit ok;
        do_reset();
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        stream(3, 0);
        wait_done(ok);
        n_checks++;
        if (stream_timeout || !ok) $display("FAIL abc_timeout: got stuck want done"); else n_pass++;
        n_checks++;
        if (log_word.size() != 1) $display("FAIL abc_xfer_count: got %0d want 1", log_word.size());
        else if (log_word[0] !== 32'h61626300) $display("FAIL abc_word: got %h want 61626300", log_word[0]);
        else n_pass++;
        n_checks++;
        if (log_last.size() != 1 || log_last[0] !== 1'b1 || log_bnum[0] !== 2'd3)
            $display("FAIL abc_last_bnum: got size=%0d want last=1 bn=3", log_last.size());
        else n_pass++;
    endtask

    task automatic test_full_word_end;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) msg[i] = 8'(i + 1);
        stream(4, 0);
        wait_done(ok);
        n_checks++;
        if (stream_timeout || !ok) $display("FAIL four_timeout: got stuck want done"); else n_pass++;
        n_checks++;
        if (log_word.size() != 2) $display("FAIL four_xfer_count: got %0d want 2", log_word.size());
        else if (log_word[0] !== 32'h01020304 || log_last[0] !== 1'b0)
            $display("FAIL four_word0: got %h last=%b want 01020304 last=0", log_word[0], log_last[0]);
        else n_pass++;
        n_checks++;
        if (log_word.size() != 2) $display("FAIL four_word1_missing: got %0d want 2", log_word.size());
        else if (log_word[1] !== 32'd0 || log_last[1] !== 1'b1 || log_bnum[1] !== 2'd0)
            $display("FAIL four_word1: got %h last=%b bn=%0d want 0 last=1 bn=0", log_word[1], log_last[1], log_bnum[1]);
        else n_pass++;
        n_checks++;
        if (log_cyc.size() == 0 || log_cyc[0] != last_acc_cyc + 1)
            $display("FAIL four_latency: got cycle %0d want %0d", (log_cyc.size() == 0) ? -1 : log_cyc[0], last_acc_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [31:0] exp_w[4];
        logic        exp_l[4];
        exp_w[0] = 32'h10111213; exp_w[1] = 32'h14151617;
        exp_w[2] = 32'h18191a1b; exp_w[3] = 32'h00000000;
        exp_l[0] = 1'b0; exp_l[1] = 1'b0; exp_l[2] = 1'b0; exp_l[3] = 1'b1;
        do_reset();
        for (int i = 0; i < 12; i++) msg[i] = 8'(8'h10 + i);
        stream(12, 10);
        wait_done(ok);
        n_checks++;
        if (stream_timeout || !ok) $display("FAIL b2b_timeout: got stuck want done"); else n_pass++;
        n_checks++;
        if (bf_viol != 0) $display("FAIL b2b_xfer_while_full: got %0d want 0", bf_viol); else n_pass++;
        n_checks++;
        if (stall != EXP_STALL) $display("FAIL b2b_stall_pattern: got %0d want %0d", stall, EXP_STALL); else n_pass++;
        n_checks++;
        if (log_word.size() != 4) $display("FAIL b2b_xfer_count: got %0d want 4", log_word.size()); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (i >= log_word.size()) $display("FAIL b2b_word%0d: got none want %h", i, exp_w[i]);
            else if (log_word[i] !== exp_w[i] || log_last[i] !== exp_l[i] || log_bnum[i] !== 2'd0)
                $display("FAIL b2b_word%0d: got %h last=%b bn=%0d want %h last=%b bn=0",
                         i, log_word[i], log_last[i], log_bnum[i], exp_w[i], exp_l[i]);
            else n_pass++;
        end
    endtask

    task automatic test_after_done;
        int ready_hi = 0;
        int not_done = 0;
        int n_before;
        n_before = log_word.size();
        for (int i = 0; i < 5; i++) begin
            byte_in = 8'hee; byte_valid = 1'b1; byte_last = 1'b1; msg_end = 1'b1;
            tick();
            if (s_byte_ready) ready_hi++;
            if (!s_done) not_done++;
        end
        idle_inputs();
        tick(); tick();
        n_checks++;
        if (ready_hi != 0) $display("FAIL done_byte_ready: got %0d high cycles want 0", ready_hi); else n_pass++;
        n_checks++;
        if (log_word.size() != n_before) $display("FAIL done_extra_xfer: got %0d want %0d", log_word.size(), n_before); else n_pass++;
        n_checks++;
        if (not_done != 0) $display("FAIL done_dropped: got %0d low cycles want 0", not_done); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int idx = 0;
        do_reset();
        for (int i = 0; i < 6; i++) msg[i] = 8'(8'hc0 + i);
        buffer_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            byte_valid = (idx < 6);
            byte_in    = msg[(idx < 6) ? idx : 5];
            tick();
            if (byte_valid && s_byte_ready) idx++;
        end
        byte_valid = 1'b0;
        n_checks++;
        if (log_word.size() != 0) $display("FAIL mid_xfer_while_full: got %0d want 0", log_word.size()); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++;
        if (s_in_ready !== 1'b0 || s_byte_ready !== 1'b0)
            $display("FAIL mid_reset_strobes: got in_ready=%b byte_ready=%b want 0 0", s_in_ready, s_byte_ready);
        else n_pass++;
        tick();
        reset = 1'b0;
        buffer_full = 1'b0;
        tick();
        n_checks++;
        if (s_in !== 32'd0 || s_in_ready !== 1'b0 || s_is_last !== 1'b0 || s_bnum !== 2'd0 || s_done !== 1'b0)
            $display("FAIL mid_reset_values: got in=%h rdy=%b last=%b bn=%0d done=%b want all 0",
                     s_in, s_in_ready, s_is_last, s_bnum, s_done);
        else n_pass++;
        tick(); tick(); tick();
        n_checks++;
        if (log_word.size() != 0) $display("FAIL mid_stale_pending: got %0d xfers want 0", log_word.size()); else n_pass++;
        msg[0] = 8'haa;
        stream(1, 0);
        wait_done(ok);
        n_checks++;
        if (stream_timeout || !ok) $display("FAIL mid_fresh_timeout: got stuck want done"); else n_pass++;
        n_checks++;
        if (log_word.size() != 1) $display("FAIL mid_fresh_count: got %0d want 1", log_word.size());
        else if (log_word[0] !== 32'haa000000 || log_last[0] !== 1'b1 || log_bnum[0] !== 2'd1)
            $display("FAIL mid_fresh_word: got %h last=%b bn=%0d want aa000000 last=1 bn=1",
                     log_word[0], log_last[0], log_bnum[0]);
        else n_pass++;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_empty_msg();
        test_abc();
        test_full_word_end();
        test_back_to_back();
        test_after_done();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
